// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch address width, sequencer states and jump-class ALU codes.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // alu_control codes that the decoder flags as branch_valid
  typedef enum logic [3:0] {
    ALU_JMP = 4'd6,
    ALU_JGT = 4'd7,
    ALU_JLT = 4'd8,
    ALU_JEQ = 4'd9
  } alu_jump_e;

  // Taken branch captured while the current fetch is still waiting on memory
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] target;
  } pend_br_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Instruction-memory fetch handshake between the PC unit and instruction memory.
interface branch_pc_unit_if;

  logic                       imem_req;
  logic [cpu_pkg::ADDR_W-1:0] imem_addr;
  logic                       imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready
  );

endinterface

// File: rtl/branch_pc_unit.sv
// PC and fetch sequencer: sequential fetch, taken-branch redirect with deferred
// application behind an unaccepted request, and a fixed-length wrong-path flush.
module branch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'h0000,
  parameter int unsigned       FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_valid,
  input  logic              rFlag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  branch_pc_unit_if.master  imem,
  output logic [ADDR_W-1:0] pc,
  output logic              flush,
  output logic              redirect,
  output logic [CNT_W-1:0]  br_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic                flush_q, flush_d;
  logic                redirect_q, redirect_d;
  logic [CNT_W-1:0]    br_count_q, br_count_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  pend_br_t            pend_q, pend_d;

  logic                taken_c;
  logic                accept_c;
  logic                load_c;
  logic [ADDR_W-1:0]   load_tgt_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
      br_count_q <= '0;
      fcnt_q     <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_count_q <= br_count_d;
      fcnt_q     <= fcnt_d;
      pend_q     <= pend_d;
    end
  end

  // Next-state, PC selection and registered-output preparation
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fcnt_d     = fcnt_q;
    pend_d     = pend_q;
    br_count_d = br_count_q;
    redirect_d = 1'b0;
    load_c     = 1'b0;
    load_tgt_c = branch_target;
    taken_c    = branch_valid & rFlag;
    accept_c   = req_q & imem.imem_ready;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end

      FETCH: begin
        // A fresh taken branch beats any pending one (last wins)
        if (taken_c && accept_c) begin
          load_c     = 1'b1;
          load_tgt_c = branch_target;
        end else if (taken_c) begin
          pend_d.valid  = 1'b1;
          pend_d.target = branch_target;
        end else if (pend_q.valid && accept_c) begin
          load_c     = 1'b1;
          load_tgt_c = pend_q.target;
        end else if (accept_c && !stall) begin
          pc_d = pc_q + ADDR_W'(1);
        end

        if (load_c) begin
          pc_d       = load_tgt_c;
          redirect_d = 1'b1;
          state_d    = FLUSH;
          fcnt_d     = FCNT_W'(FLUSH_CYCLES);
          pend_d     = '0;
          if (br_count_q != '1) begin
            br_count_d = br_count_q + CNT_W'(1);
          end
        end
      end

      FLUSH: begin
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d = FETCH;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q - FCNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_d   = (state_d == FETCH);
    flush_d = (state_d == FLUSH);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign flush          = flush_q;
  assign redirect       = redirect_q;
  assign br_count       = br_count_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed-vector bench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        branch_valid;
  logic        rflag;
  logic [15:0] branch_target;
  logic        stall;
  logic [15:0] pc;
  logic        flush;
  logic        redirect;
  logic [15:0] br_count;

  int n_vec;
  int n_err;

  branch_pc_unit_if bus ();

  branch_pc_unit #(
    .RESET_PC     (16'h0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branch_valid  (branch_valid),
    .rFlag         (rflag),
    .branch_target (branch_target),
    .stall         (stall),
    .imem          (bus.master),
    .pc            (pc),
    .flush         (flush),
    .redirect      (redirect),
    .br_count      (br_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; branch_valid = 1'b0; rflag = 1'b0; branch_target = '0;
    stall = 1'b0; bus.imem_ready = 1'b1;
    #12;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
    n_vec++; if (pc !== 16'h0000) begin n_err++; $display("FAIL rst_pc got %h want 0000", pc); end
    n_vec++; if (flush !== 1'b0 || redirect !== 1'b0) begin n_err++; $display("FAIL rst_flush_redirect got %b%b want 00", flush, redirect); end
    n_vec++; if (br_count !== 16'h0000) begin n_err++; $display("FAIL rst_br_count got %h want 0000", br_count); end
    step();
    rst_n = 1'b1;
    #2;
    n_vec++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL idle_dead_cycle got req %b want 0", bus.imem_req); end
    step();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000) begin
      n_err++; $display("FAIL first_req got req %b addr %h want 1 0000", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_seq_fetch();
    for (int i = 1; i <= 5; i++) begin
      step();
      n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'(i)) begin
        n_err++; $display("FAIL seq_addr%0d got req %b addr %h want 1 %h", i, bus.imem_req, bus.imem_addr, 16'(i));
      end
    end
  endtask

  task automatic test_ready_hold();
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0005 || pc !== 16'h0005) begin
        n_err++; $display("FAIL hold_addr5_c%0d got req %b addr %h pc %h want 1 0005 0005", i, bus.imem_req, bus.imem_addr, pc);
      end
    end
    bus.imem_ready = 1'b1;
    step();
    n_vec++; if (pc !== 16'h0006) begin n_err++; $display("FAIL hold_accept got pc %h want 0006", pc); end
  endtask

  task automatic test_branch_taken();
    step(); step();
    n_vec++; if (pc !== 16'h0008) begin n_err++; $display("FAIL pre_branch_pc got %h want 0008", pc); end
    branch_valid = 1'b1; rflag = 1'b1; branch_target = 16'h0100;
    step();
    branch_valid = 1'b0; rflag = 1'b0;
    n_vec++; if (pc !== 16'h0100 || redirect !== 1'b1 || flush !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL br_n1 got pc %h redir %b flush %b req %b want 0100 1 1 0", pc, redirect, flush, bus.imem_req);
    end
    step();
    n_vec++; if (redirect !== 1'b0 || flush !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_err++; $display("FAIL br_n2 got redir %b flush %b req %b want 0 1 0", redirect, flush, bus.imem_req);
    end
    step();
    n_vec++; if (flush !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0100) begin
      n_err++; $display("FAIL br_n3 got flush %b req %b addr %h want 0 1 0100", flush, bus.imem_req, bus.imem_addr);
    end
    n_vec++; if (br_count !== 16'h0001) begin n_err++; $display("FAIL br_count1 got %h want 0001", br_count); end
  endtask

  task automatic test_pending_branch();
    int redirs;
    redirs = 0;
    bus.imem_ready = 1'b0;
    branch_valid = 1'b1; rflag = 1'b1; branch_target = 16'h0180;
    step();
    n_vec++; if (pc !== 16'h0100 || redirect !== 1'b0 || flush !== 1'b0 || bus.imem_req !== 1'b1) begin
      n_err++; $display("FAIL pend1 got pc %h redir %b flush %b req %b want 0100 0 0 1", pc, redirect, flush, bus.imem_req);
    end
    branch_target = 16'h0200;
    step();
    n_vec++; if (pc !== 16'h0100 || bus.imem_addr !== 16'h0100) begin
      n_err++; $display("FAIL pend2 got pc %h addr %h want 0100 0100", pc, bus.imem_addr);
    end
    branch_valid = 1'b0; rflag = 1'b0; bus.imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (redirect === 1'b1) redirs++;
    end
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0200) begin
      n_err++; $display("FAIL pend_target got req %b addr %h want 1 0200", bus.imem_req, bus.imem_addr);
    end
    n_vec++; if (redirs !== 1) begin n_err++; $display("FAIL pend_redirects got %0d want 1", redirs); end
    n_vec++; if (br_count !== 16'h0002) begin n_err++; $display("FAIL br_count2 got %h want 0002", br_count); end
  endtask

  task automatic test_fallthrough_stall();
    branch_valid = 1'b1; rflag = 1'b0; branch_target = 16'h0ABC; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (pc !== 16'h0200 || flush !== 1'b0 || redirect !== 1'b0 || bus.imem_req !== 1'b1) begin
        n_err++; $display("FAIL ft_stall_c%0d got pc %h flush %b redir %b req %b want 0200 0 0 1", i, pc, flush, redirect, bus.imem_req);
      end
    end
    n_vec++; if (br_count !== 16'h0002) begin n_err++; $display("FAIL ft_br_count got %h want 0002", br_count); end
    branch_valid = 1'b0; stall = 1'b0;
  endtask

  task automatic test_wrap_and_flush_ignore();
    branch_valid = 1'b1; rflag = 1'b1; branch_target = 16'hFFFF;
    step();
    branch_target = 16'h1234;
    step();
    n_vec++; if (pc !== 16'hFFFF || flush !== 1'b1) begin
      n_err++; $display("FAIL flush_ignore got pc %h flush %b want ffff 1", pc, flush);
    end
    step();
    branch_valid = 1'b0; rflag = 1'b0;
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'hFFFF || br_count !== 16'h0003) begin
      n_err++; $display("FAIL wrap_pre got req %b addr %h cnt %h want 1 ffff 0003", bus.imem_req, bus.imem_addr, br_count);
    end
    step();
    n_vec++; if (bus.imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_addr got %h want 0000", bus.imem_addr); end
  endtask

  task automatic test_reset_mid_flush();
    branch_valid = 1'b1; rflag = 1'b1; branch_target = 16'h0300;
    step();
    branch_valid = 1'b0; rflag = 1'b0;
    n_vec++; if (flush !== 1'b1 || pc !== 16'h0300) begin
      n_err++; $display("FAIL mid_flush_entry got flush %b pc %h want 1 0300", flush, pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (flush !== 1'b0 || pc !== 16'h0000 || redirect !== 1'b0 || bus.imem_req !== 1'b0 || br_count !== 16'h0000) begin
      n_err++; $display("FAIL async_rst got flush %b pc %h redir %b req %b cnt %h want 0 0000 0 0 0000",
                        flush, pc, redirect, bus.imem_req, br_count);
    end
    step();
    rst_n = 1'b1;
    step();
    n_vec++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 16'h0000 || flush !== 1'b0) begin
      n_err++; $display("FAIL post_rst_req got req %b addr %h flush %b want 1 0000 0", bus.imem_req, bus.imem_addr, flush);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_seq_fetch();
    test_ready_hold();
    test_branch_taken();
    test_pending_branch();
    test_fallthrough_stall();
    test_wrap_and_flush_ignore();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and fetch sequencer that consumes the `rFlag` branch decision from the comparator and steers instruction fetch. It holds the PC, issues valid/ready fetch requests to instruction memory, loads the branch target on a taken branch, and flushes the wrong-path instructions already in flight. It sits between the execute-stage comparator and the instruction memory port of the 16-bit CPU.

## Interface

- `ADDR_W`, 16, PC / fetch address width
- `RESET_PC`, 16'h0000, PC value after reset
- `FLUSH_CYCLES`, 2, cycles `flush` stays high after a redirect (1..7)

- `clk` in 1: single clock; all state changes on its rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `branch_valid` in 1: execute stage holds a jump-class instruction (alu_control 6..9) this cycle
- `rFlag` in 1: branch taken; meaningful only while `branch_valid`=1
- `branch_target` in ADDR_W: jump destination; sampled with `branch_valid`
- `stall` in 1: downstream cannot accept a new instruction; blocks PC advance
- `imem_req` out 1: fetch request valid
- `imem_addr` out ADDR_W: fetch address; equals `pc` while `imem_req`=1
- `imem_ready` in 1: memory accepts the request this cycle
- `pc` out ADDR_W: current fetch PC
- `flush` out 1: kill instructions in fetch/decode
- `redirect` out 1: one-cycle pulse when PC is loaded from a target
- `br_count` out 16: taken-branch count, saturating

## Operation

- States: IDLE, FETCH, FLUSH.
- Reset (asynchronous): state=IDLE, `pc`=RESET_PC, `imem_req`=0, `flush`=0, `redirect`=0, `br_count`=0, pending-branch flag clear.
- IDLE: unconditionally -> FETCH on the next edge (one dead cycle after reset release).
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - Accept = `imem_req` & `imem_ready`. On accept with `stall`=0 and no taken branch: `pc` <= `pc`+1, mod 2^ADDR_W (16'hFFFF -> 16'h0000).
  - Accept with `stall`=1: request completes; `pc` holds; the same address is re-requested next cycle.
  - While `imem_req`=1 and `imem_ready`=0: `imem_addr` held stable, never withdrawn.
- Taken branch = `branch_valid` & `rFlag`. `branch_valid` & !`rFlag` has no effect (fall-through).
  - In FETCH with no outstanding unaccepted request (accept this cycle or `imem_ready`=1): `pc` <= `branch_target`, `redirect`=1 next cycle, state -> FLUSH. Taken branch overrides both increment and stall.
  - In FETCH with `imem_ready`=0: target latched into a pending register; on the cycle the request is accepted, `pc` <= pending target and state -> FLUSH; pending flag clears. A second taken branch while pending overwrites the target (last wins).
  - In FLUSH: taken branches ignored (shadow instructions are being killed).
- FLUSH: `imem_req`=0, `flush`=1 for exactly FLUSH_CYCLES cycles (3-bit down-counter), then -> FETCH.
- `br_count` increments once per applied redirect; holds at 16'hFFFF.

## Timing

- Taken branch sampled at edge N (request idle or accepted): `pc`=target, `redirect`=1, `flush`=1 from N+1; `flush` high through N+FLUSH_CYCLES; `imem_req`=1 with `imem_addr`=target at N+FLUSH_CYCLES+1.
- Sequential fetch: one address per cycle when `imem_ready`=1 and `stall`=0.
- `redirect` is a registered single-cycle pulse; `flush`, `imem_req` and `pc` are registered outputs (no combinational input-to-output paths).
- Reset asserted mid-FLUSH or with a pending branch: all state is discarded immediately; first request after release is RESET_PC.

## Structure

- Shared package `cpu_pkg`: state enum (IDLE/FETCH/FLUSH), `ADDR_W`, alu_control jump codes (JMP=6, JGT=7, JLT=8, JEQ=9) shared with the comparator and decoder.
- Single module, no sub-modules; the flush counter and saturating `br_count` are inline.

## Test plan

- Reset release, `imem_ready`=1, no branches -> `imem_addr` 0,1,2,3 on consecutive cycles starting one cycle after IDLE.
- `imem_ready` low 3 cycles at addr 5 -> `imem_addr` held at 5, `pc` advances to 6 only after accept.
- Taken branch to 16'h0100 at PC 8, FLUSH_CYCLES=2 -> `redirect` 1 cycle, `flush` 2 cycles, next request addr 16'h0100; `br_count`=1.
- Taken branch while `imem_ready`=0, then a second one to 16'h0200 -> after accept, redirect to 16'h0200, only one redirect, `br_count`=1.
- `branch_valid`=1, `rFlag`=0 with `stall`=1 -> `pc` holds; no flush; `br_count` unchanged.
- PC at 16'hFFFF accepted -> next address 16'h0000; `rst_n` low mid-FLUSH -> `flush`=0, `pc`=RESET_PC immediately.
